multi_port_fifo: RTL and testbench

//  Multi-lane successor of the single-lane handshake FIFO. Up to NUM_IN entries are pushed
//  and up to NUM_OUT entries popped per cycle, in strict FIFO order.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/multi_port_fifo_if.sv | 33 +++
 rtl/fifo_lane_compact.sv | 23 ++
 rtl/multi_port_fifo.sv | 122 ++++++++++++
 tb/tb_multi_port_fifo.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: lane popcount, prefix check and pointer type.
package fifo_pkg;

  localparam int MAX_LANES  = 16;
  localparam int LANE_CNT_W = $clog2(MAX_LANES + 1);
  localparam int DEF_DEPTH  = 16;

  typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;

  function automatic logic [LANE_CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [LANE_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + LANE_CNT_W'(v[i]);
    end
    return n;
  endfunction

  // A run of ones starting at bit 0 (including all-zero) turns into a single carry when incremented.
  function automatic logic is_prefix(input logic [MAX_LANES-1:0] v);
    return (v & (v + MAX_LANES'(1))) == '0;
  endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Push/pop bundle of the multi-lane FIFO; slave is the FIFO, master is producer plus consumer.
interface multi_port_fifo_if
  import fifo_pkg::*;
#(
  parameter type T       = logic [31:0],
  parameter int  DEPTH   = DEF_DEPTH,
  parameter int  NUM_IN  = 4,
  parameter int  NUM_OUT = 4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic [NUM_IN-1:0]     push_valid_i;
  T     [NUM_IN-1:0]     push_data_i;
  logic                  push_ready_o;
  logic [NUM_OUT-1:0]    pop_valid_o;
  T     [NUM_OUT-1:0]    pop_data_o;
  logic [NUM_OUT-1:0]    pop_ready_i;
  logic [CNT_W-1:0]      count_o;
  logic                  almost_full_o;

  modport slave (
    input  flush_i, push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o, count_o, almost_full_o
  );

  modport master (
    output flush_i, push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o, count_o, almost_full_o
  );

endinterface

// File: rtl/fifo_lane_compact.sv
// Push-lane compaction: exclusive prefix sum of the accepted valids gives each lane its slot.
module fifo_lane_compact #(
  parameter int NUM_IN = 4,
  parameter int OFF_W  = $clog2(NUM_IN + 1)
) (
  input  logic [NUM_IN-1:0]            valid_i,
  output logic [NUM_IN-1:0][OFF_W-1:0] offset_o,
  output logic [OFF_W-1:0]             n_push_o
);

  logic [OFF_W-1:0] run;

  always_comb begin
    run      = '0;
    offset_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      offset_o[i] = run;
      run         = run + OFF_W'(valid_i[i]);
    end
    n_push_o = run;
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane FIFO: up to NUM_IN pushes and NUM_OUT pops per cycle in strict order,
// with synchronous flush, registered occupancy and an almost-full flag.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  NUM_IN    = 4,
  parameter int  NUM_OUT   = 4,
  parameter int  AF_THRESH = DEPTH - NUM_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_port_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW1   = CNT_W + 1;
  localparam int OFF_W = $clog2(NUM_IN + 1);

  localparam logic [CW1-1:0] DEPTH_W  = CW1'(DEPTH);
  localparam logic [CW1-1:0] NUM_IN_W = CW1'(NUM_IN);
  localparam logic [CW1-1:0] AF_W     = CW1'(AF_THRESH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ready_q, push_ready_d;
  logic             almost_full_q, almost_full_d;
  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];

  logic [NUM_IN-1:0]            push_en;
  logic [NUM_IN-1:0][OFF_W-1:0] offset;
  logic [OFF_W-1:0]             n_push;
  logic [LANE_CNT_W-1:0]        n_pop;
  logic [CW1-1:0]               cnt_n;
  logic [NUM_OUT-1:0]           pop_valid;
  T     [NUM_OUT-1:0]           pop_data;

  assign push_en = bus.push_valid_i & {NUM_IN{push_ready_q}};

  fifo_lane_compact #(
    .NUM_IN (NUM_IN),
    .OFF_W  (OFF_W)
  ) u_compact (
    .valid_i  (push_en),
    .offset_o (offset),
    .n_push_o (n_push)
  );

  // Read side sees only registered state, so a push becomes visible one cycle later.
  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      pop_valid[j] = cnt_q > CNT_W'(j);
      pop_data[j]  = mem_q[rptr_q + PTR_W'(j)];
    end
  end

  assign n_pop = popcount(MAX_LANES'(pop_valid & bus.pop_ready_i));

  always_comb begin
    cnt_n         = CW1'(cnt_q) + CW1'(n_push) - CW1'(n_pop);
    mem_d         = mem_q;
    wptr_d        = wptr_q + PTR_W'(n_push);
    rptr_d        = rptr_q + PTR_W'(n_pop);
    cnt_d         = cnt_n[CNT_W-1:0];
    push_ready_d  = (DEPTH_W - cnt_n) >= NUM_IN_W;
    almost_full_d = cnt_n >= AF_W;
    for (int i = 0; i < NUM_IN; i++) begin
      if (push_en[i]) begin
        mem_d[wptr_q + PTR_W'(offset[i])] = bus.push_data_i[i];
      end
    end
    if (bus.flush_i) begin
      mem_d         = mem_q;
      wptr_d        = '0;
      rptr_d        = '0;
      cnt_d         = '0;
      push_ready_d  = 1'b1;
      almost_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      push_ready_q  <= 1'b0;
      almost_full_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      push_ready_q  <= push_ready_d;
      almost_full_q <= almost_full_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.push_ready_o  = push_ready_q;
  assign bus.pop_valid_o   = pop_valid;
  assign bus.pop_data_o    = pop_data;
  assign bus.count_o       = cnt_q;
  assign bus.almost_full_o = almost_full_q;

  a_pop_ready_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    is_prefix(MAX_LANES'(bus.pop_ready_i)));

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_n <= DEPTH_W);

endmodule

// File: tb/tb_multi_port_fifo.sv
// Randomized bench for multi_port_fifo against a queue model of occupancy and order.
module tb_multi_port_fifo;

  localparam int DEPTH   = 16;
  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int AF      = DEPTH - NUM_IN;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] model_q[$];
  bit          model_live = 1'b0;

  multi_port_fifo_if #(
    .T(logic [31:0]), .DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)
  ) bus ();

  multi_port_fifo #(
    .T(logic [31:0]), .DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .AF_THRESH(AF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return model_live && ((DEPTH - model_q.size()) >= NUM_IN);
  endfunction

  function automatic logic [NUM_OUT-1:0] model_valid();
    logic [NUM_OUT-1:0] v;
    for (int j = 0; j < NUM_OUT; j++) v[j] = (model_q.size() > j);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.flush_i      = 1'b0;
    bus.push_valid_i = '0;
    bus.push_data_i  = '0;
    bus.pop_ready_i  = '0;
  endtask

  // One clock edge; the model applies pops to the oldest entries, then appends accepted pushes.
  task automatic tick();
    bit rdy;
    int n_pop;
    rdy = model_ready();
    @(posedge clk);
    if (bus.flush_i) begin
      model_q.delete();
    end else begin
      n_pop = 0;
      for (int j = 0; j < NUM_OUT; j++) if (bus.pop_ready_i[j] && (j < model_q.size())) n_pop++;
      repeat (n_pop) void'(model_q.pop_front());
      if (rdy) for (int i = 0; i < NUM_IN; i++) if (bus.push_valid_i[i]) model_q.push_back(bus.push_data_i[i]);
    end
    model_live = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    model_q.delete();
    model_live = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.push_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", bus.push_ready_o); end
    total++; if (bus.pop_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_pop_valid got=%b exp=0000", bus.pop_valid_o); end
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.almost_full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_af got=%b exp=0", bus.almost_full_o); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.push_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL idle_ready cyc=%0d got=%b exp=1", c, bus.push_ready_o); end
      total++; if (bus.pop_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL idle_pop_valid cyc=%0d got=%b exp=0000", c, bus.pop_valid_o); end
      total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL idle_count cyc=%0d got=%0d exp=0", c, bus.count_o); end
    end
  endtask

  task automatic test_sparse_push();
    logic [NUM_IN-1:0][31:0] d;
    for (int i = 0; i < NUM_IN; i++) d[i] = $urandom;
    bus.push_valid_i = 4'b1010;
    bus.push_data_i  = d;
    tick();
    idle_inputs();
    total++; if (bus.pop_valid_o !== 4'b0011) begin bad++; $display("[TB] FAIL sparse_valid got=%b exp=0011", bus.pop_valid_o); end
    total++; if (bus.pop_data_o[0] !== d[1]) begin bad++; $display("[TB] FAIL sparse_lane0 got=%h exp=%h", bus.pop_data_o[0], d[1]); end
    total++; if (bus.pop_data_o[1] !== d[3]) begin bad++; $display("[TB] FAIL sparse_lane1 got=%h exp=%h", bus.pop_data_o[1], d[3]); end
    total++; if (bus.count_o !== 5'd2) begin bad++; $display("[TB] FAIL sparse_count got=%0d exp=2", bus.count_o); end
    bus.pop_ready_i = 4'b0011;
    tick();
    idle_inputs();
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL sparse_drain got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_fill_wrap();
    int exp_cnt;
    bus.flush_i = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      bus.push_valid_i = 4'b1111;
      for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
      tick();
      idle_inputs();
      exp_cnt = 4 * k;
      total++; if (bus.count_o !== 5'(exp_cnt)) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=%0d", bus.count_o, exp_cnt); end
      total++; if (bus.push_ready_o !== ((DEPTH - exp_cnt) >= NUM_IN)) begin bad++; $display("[TB] FAIL fill_ready cnt=%0d got=%b", exp_cnt, bus.push_ready_o); end
      total++; if (bus.almost_full_o !== (exp_cnt >= AF)) begin bad++; $display("[TB] FAIL fill_af cnt=%0d got=%b", exp_cnt, bus.almost_full_o); end
    end
    bus.pop_ready_i  = 4'b0011;
    bus.push_valid_i = 4'b1111;
    for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
    tick();
    idle_inputs();
    total++; if (bus.count_o !== 5'd14) begin bad++; $display("[TB] FAIL wrap_count got=%0d exp=14", bus.count_o); end
    total++; if (dut.rptr_q !== 4'd2) begin bad++; $display("[TB] FAIL wrap_rptr got=%0d exp=2", dut.rptr_q); end
    total++; if (bus.push_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ready got=%b exp=0", bus.push_ready_o); end
    for (int c = 0; c < 20 && model_q.size() > 0; c++) begin
      bus.pop_ready_i = 4'b1111;
      if (c < 3) begin
        bus.push_valid_i = 4'b1111;
        for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
      end
      tick();
      idle_inputs();
      total++; if (bus.count_o !== 5'(model_q.size())) begin bad++; $display("[TB] FAIL drain_count got=%0d exp=%0d", bus.count_o, model_q.size()); end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (j < model_q.size()) begin
          total++; if (bus.pop_data_o[j] !== model_q[j]) begin bad++; $display("[TB] FAIL drain_data lane=%0d got=%h exp=%h", j, bus.pop_data_o[j], model_q[j]); end
        end
      end
    end
    total++; if (bus.pop_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL drain_empty got=%b exp=0000", bus.pop_valid_o); end
  endtask

  task automatic test_flush();
    logic [31:0] x;
    bus.flush_i = 1'b1;
    tick();
    idle_inputs();
    bus.push_valid_i = 4'b1111;
    for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
    tick();
    bus.push_valid_i = 4'b0111;
    for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
    tick();
    idle_inputs();
    total++; if (bus.count_o !== 5'd7) begin bad++; $display("[TB] FAIL flush_hold got=%0d exp=7", bus.count_o); end
    bus.flush_i      = 1'b1;
    bus.push_valid_i = 4'b1111;
    bus.pop_ready_i  = 4'b1111;
    for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
    tick();
    idle_inputs();
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.pop_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL flush_valid got=%b exp=0000", bus.pop_valid_o); end
    total++; if (bus.push_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready got=%b exp=1", bus.push_ready_o); end
    total++; if (bus.almost_full_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_af got=%b exp=0", bus.almost_full_o); end
    x = $urandom;
    bus.push_valid_i   = 4'b0001;
    bus.push_data_i[0] = x;
    tick();
    idle_inputs();
    total++; if (bus.pop_data_o[0] !== x || bus.count_o !== 5'd1) begin bad++; $display("[TB] FAIL flush_restart got=%h/%0d exp=%h/1", bus.pop_data_o[0], bus.count_o, x); end
    bus.flush_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      bus.push_valid_i = (k < 2) ? 4'b1111 : 4'b0001;
      for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
      tick();
    end
    idle_inputs();
    total++; if (bus.count_o !== 5'd9) begin bad++; $display("[TB] FAIL areset_hold got=%0d exp=9", bus.count_o); end
    #2 rst_n = 1'b0;
    model_q.delete();
    model_live = 1'b0;
    #1;
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL areset_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.pop_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL areset_valid got=%b exp=0000", bus.pop_valid_o); end
    total++; if (bus.push_ready_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin bad++; $display("[TB] FAIL areset_flags got=%b%b exp=00", bus.push_ready_o, bus.almost_full_o); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.push_ready_o !== 1'b1 || bus.pop_valid_o !== 4'b0000 || bus.count_o !== 5'd0) begin
        bad++; $display("[TB] FAIL areset_restart cyc=%0d got=%b/%b/%0d exp=1/0000/0", c, bus.push_ready_o, bus.pop_valid_o, bus.count_o);
      end
    end
  endtask

  task automatic test_random_traffic();
    int k;
    for (int c = 0; c < 10000; c++) begin
      bus.push_valid_i = 4'($urandom);
      for (int i = 0; i < NUM_IN; i++) bus.push_data_i[i] = $urandom;
      k = ((c / 500) % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 4);
      bus.pop_ready_i = 4'((1 << k) - 1);
      bus.flush_i     = ($urandom_range(0, 99) == 0);
      tick();
      total++; if (bus.count_o !== 5'(model_q.size())) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.count_o, model_q.size()); end
      total++; if (bus.push_ready_o !== model_ready()) begin bad++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.push_ready_o, model_ready()); end
      total++; if (bus.almost_full_o !== (model_q.size() >= AF)) begin bad++; $display("[TB] FAIL rnd_af cyc=%0d got=%b size=%0d", c, bus.almost_full_o, model_q.size()); end
      total++; if (bus.pop_valid_o !== model_valid()) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.pop_valid_o, model_valid()); end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (j < model_q.size()) begin
          total++; if (bus.pop_data_o[j] !== model_q[j]) begin bad++; $display("[TB] FAIL rnd_data cyc=%0d lane=%0d got=%h exp=%h", c, j, bus.pop_data_o[j], model_q[j]); end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_sparse_push();
    test_fill_wrap();
    test_flush();
    test_async_reset();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
